fpu_arbiter: RTL and testbench
==============================

Name: fpu_arbiter

Overview:
- Shares one FPU instance between two requesters: requester 0 is the integer/FP issue stage, requester 1 is the auxiliary (e.g. vector/loader) port.
- Round-robin arbitration. The granted operation's operands are captured and driven to the FPU. The controller issues the single-cycle enable, waits for the FPU ready pulse, then returns the result to the originating requester over a valid/ready response channel.
- Guards against illegal opcodes and a hung FPU with an error response.

Parameters:
- CTL_MAX, 20: highest legal FPU opcode; ctl > CTL_MAX is illegal.
- TIMEOUT, 31: maximum WAIT cycles before the operation is aborted with an error.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_ctl  in  5  opcode
- req0_x1  in  32  operand 1
- req0_x2  in  32  operand 2
- req1_valid, req1_ready, req1_ctl, req1_x1, req1_x2: same as requester 0, for requester 1
- rsp0_valid  out  1  result for requester 0 pending
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_y  out  32  result
- rsp0_err  out  1  illegal opcode or timeout
- rsp1_valid, rsp1_ready, rsp1_y, rsp1_err: same as requester 0, for requester 1
- fpu_en  out  1  one-cycle start pulse to FPU
- fpu_ctl  out  5  opcode to FPU, held stable from ISSUE through WAIT
- fpu_x1  out  32  operand 1 to FPU, held stable
- fpu_x2  out  32  operand 2 to FPU, held stable
- fpu_ready  in  1  FPU one-cycle done pulse
- fpu_y  in  32  FPU result, valid while fpu_ready=1
- busy  out  1  state != IDLE

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE; all valid/ready/en/err=0; all y, fpu_ctl, fpu_x1, fpu_x2=0; timeout counter=0; last_grant=1, so requester 0 wins the first tie. Reset mid-operation abandons the operation; no response is produced. A stray fpu_ready after reset is ignored because the controller is not in WAIT.
- req*_ready is combinational. It is asserted only in IDLE, for the granted requester only, and at most one is high per cycle. A transfer occurs when valid and ready are both high.
- Arbitration in IDLE:
  - one valid requester: grant it.
  - both valid: grant the requester != last_grant.
  - last_grant updates on each accept.
- On accept (cycle T): latch ctl/x1/x2 into fpu_* registers and latch the owner id.
  - ctl <= CTL_MAX: go to ISSUE.
  - ctl > CTL_MAX: go to RESP with y=0, err=1. The FPU is never enabled.
- ISSUE (T+1): fpu_en=1 for exactly this cycle; clear the timeout counter; go to WAIT. fpu_ready seen in ISSUE is ignored.
- WAIT:
  - fpu_en=0; fpu_ctl/x1/x2 held unchanged.
  - fpu_ready=1: capture fpu_y into the response register, err=0, go to RESP.
  - otherwise: increment the counter. When counter == TIMEOUT with no fpu_ready, go to RESP with y=0, err=1.
  - fpu_ready takes priority if it coincides with the timeout.
- RESP:
  - rsp<owner>_valid=1, with y/err stable until rsp<owner>_ready=1. The other rsp*_valid stays 0.
  - On the handshake, go to IDLE; new accepts are possible in the following cycle. There is no accept during the handshake cycle.
- Latency: accept at T; en at T+1; with an FPU of pipeline depth N, fpu_ready arrives at T+2+N and rsp_valid asserts at T+3+N. A zero-depth op (fabs) gives rsp_valid at T+3.
- Only one operation is in flight; requests stay pending (valid held) while busy.

Test Plan:
- req0 ctl=0, x1=0x3F800000, x2=0x40000000, FPU model with depth 1 → fpu_en pulses once at T+1; rsp0_valid at T+4 with rsp0_y=0x40400000, err=0.
- req0 (ctl=2) and req1 (ctl=12) valid in the same cycle from reset → req0 served first, then req1; a second simultaneous pair → req0 served first again (last_grant=1).
- rsp1_ready held low 6 cycles while req0 is valid → rsp1_valid and rsp1_y stable; req0_ready stays 0; req0 accepted the cycle after the handshake.
- req1 ctl=25 → rsp1_valid at T+1 with y=0, err=1; fpu_en never asserted.
- FPU model never raises fpu_ready, TIMEOUT=31 → rsp0_err=1, y=0 after 32 WAIT cycles. Then assert fpu_ready late while IDLE → ignored, no response.
- Assert rstn=0 for 1 cycle during WAIT → all outputs 0, busy=0; the next request completes normally.

Source files
------------

// File: rtl/fpu_arbiter_if.sv
// Request, response and FPU-side signals of the shared-FPU arbiter.
// The slave modport is the arbiter view; the master modport is the requester/FPU environment view.
interface fpu_arbiter_if;
  logic        req0_valid, req0_ready;
  logic [4:0]  req0_ctl;
  logic [31:0] req0_x1, req0_x2;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_ctl;
  logic [31:0] req1_x1, req1_x2;
  logic        rsp0_valid, rsp0_ready, rsp0_err;
  logic [31:0] rsp0_y;
  logic        rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0] rsp1_y;
  logic        fpu_en, fpu_ready;
  logic [4:0]  fpu_ctl;
  logic [31:0] fpu_x1, fpu_x2, fpu_y;
  logic        busy;

  modport slave (
    input  req0_valid, req0_ctl, req0_x1, req0_x2,
    input  req1_valid, req1_ctl, req1_x1, req1_x2,
    input  rsp0_ready, rsp1_ready, fpu_ready, fpu_y,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_y, rsp0_err, rsp1_valid, rsp1_y, rsp1_err,
    output fpu_en, fpu_ctl, fpu_x1, fpu_x2, busy
  );

  modport master (
    output req0_valid, req0_ctl, req0_x1, req0_x2,
    output req1_valid, req1_ctl, req1_x1, req1_x2,
    output rsp0_ready, rsp1_ready, fpu_ready, fpu_y,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_y, rsp0_err, rsp1_valid, rsp1_y, rsp1_err,
    input  fpu_en, fpu_ctl, fpu_x1, fpu_x2, busy
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin sharing of one FPU between two requesters, one operation in flight,
// with illegal-opcode and FPU-timeout error responses.
module fpu_arbiter #(
  parameter int CTL_MAX = 20,
  parameter int TIMEOUT = 31,
  parameter int CNT_W   = 5
) (
  input  logic          clk,
  input  logic          rstn,
  fpu_arbiter_if.slave  bus
);
  localparam logic [4:0]       CTL_LIM = 5'(CTL_MAX);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef struct packed {
    logic [4:0]  ctl;
    logic [31:0] x1;
    logic [31:0] x2;
  } op_t;

  state_e           state_q, state_d;
  op_t              op_q, op_d, sel;
  logic             owner_q, owner_d, last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      y_q, y_d;
  logic             err_q, err_d;
  logic             gnt0, gnt1, rsp_hs, rsp0_v, rsp1_v;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign rsp0_v = (state_q == RESP) && !owner_q;
  assign rsp1_v = (state_q == RESP) &&  owner_q;
  assign rsp_hs = (rsp0_v && bus.rsp0_ready) || (rsp1_v && bus.rsp1_ready);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    err_d   = err_q;
    sel     = gnt1 ? {bus.req1_ctl, bus.req1_x1, bus.req1_x2}
                   : {bus.req0_ctl, bus.req0_x1, bus.req0_x2};
    case (state_q)
      IDLE: if (gnt0 || gnt1) begin
        op_d    = sel;
        owner_d = gnt1;
        last_d  = gnt1;
        if (sel.ctl > CTL_LIM) begin
          // Illegal opcode: answer directly, the FPU is never started.
          y_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.fpu_ready) begin
          y_d     = bus.fpu_y;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TMO) begin
          y_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      op_q    <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.fpu_en     = (state_q == ISSUE);
  assign bus.fpu_ctl    = op_q.ctl;
  assign bus.fpu_x1     = op_q.x1;
  assign bus.fpu_x2     = op_q.x2;
  assign bus.rsp0_valid = rsp0_v;
  assign bus.rsp1_valid = rsp1_v;
  assign bus.rsp0_y     = rsp0_v ? y_q : '0;
  assign bus.rsp1_y     = rsp1_v ? y_q : '0;
  assign bus.rsp0_err   = rsp0_v & err_q;
  assign bus.rsp1_err   = rsp1_v & err_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: transaction-level model checked every cycle, directed
// scenarios with literal latency/value checks, then randomized traffic with FPU noise.
module tb_fpu_arbiter;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fpu_arbiter_if bus();
  fpu_arbiter #(.CTL_MAX(20), .TIMEOUT(31), .CNT_W(5)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  function automatic logic [31:0] fpu_fn(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    if (c == 5'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a ^ {b[15:0], b[31:16]}) + {27'd0, c};
  endfunction

  // FPU responder: done pulse depth+1 cycles after the enable cycle; depth<0 never answers.
  int   cd = 0, depth = 1;
  bit   stray = 0, noise_on = 0;
  logic fpu_hit;
  always @(negedge clk) begin
    #1;
    fpu_hit = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) fpu_hit = 1'b1;
    end
    if (bus.fpu_en && depth >= 0) cd = depth + 1;
    bus.fpu_ready = fpu_hit | stray | (noise_on && $urandom_range(0, 31) == 0);
    bus.fpu_y     = fpu_hit ? fpu_fn(bus.fpu_ctl, bus.fpu_x1, bus.fpu_x2)
                  : (bus.fpu_ready ? $urandom : 32'd0);
  end

  // Transaction-level model: op in flight, its age since accept, pending response.
  logic        m_busy, m_rsp, m_owner, m_legal, m_err, m_last;
  logic [4:0]  m_ctl;
  logic [31:0] m_x1, m_x2, m_y;
  int          m_age;
  bit          armed = 0;
  logic        v0, v1, e_r0, e_r1, prev_rspv = 1'b0;
  bit          hs0 = 0, hs1 = 0, rh0 = 0, rh1 = 0;
  int          cyc = 0, acc_cyc = 0, rspv_cyc = 0, rh_cyc = 0, en_cnt = 0, rsp_cnt = 0;
  logic [31:0] last_y;
  logic        last_err;
  bit          acc_log[$];

  always @(negedge clk) begin
    #2;
    cyc++;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (armed && !m_busy) begin
      if (v0 && v1) begin e_r0 = m_last; e_r1 = !m_last; end
      else begin e_r0 = v0; e_r1 = v1; end
    end
    if (armed) begin
      chk("busy", bus.busy, m_busy);
      chk("fpu_en", bus.fpu_en, m_busy && !m_rsp && m_legal && m_age == 1);
      chk("req0_ready", bus.req0_ready, e_r0);
      chk("req1_ready", bus.req1_ready, e_r1);
      chk("rsp0_valid", bus.rsp0_valid, m_rsp && !m_owner);
      chk("rsp1_valid", bus.rsp1_valid, m_rsp && m_owner);
      chk("rsp0_y", bus.rsp0_y, (m_rsp && !m_owner) ? m_y : 32'd0);
      chk("rsp1_y", bus.rsp1_y, (m_rsp && m_owner) ? m_y : 32'd0);
      chk("rsp0_err", bus.rsp0_err, m_rsp && !m_owner && m_err);
      chk("rsp1_err", bus.rsp1_err, m_rsp && m_owner && m_err);
      chk("fpu_ctl", bus.fpu_ctl, m_ctl);
      chk("fpu_x1", bus.fpu_x1, m_x1);
      chk("fpu_x2", bus.fpu_x2, m_x2);
    end
    hs0 = v0 && bus.req0_ready;
    hs1 = v1 && bus.req1_ready;
    rh0 = bus.rsp0_valid && bus.rsp0_ready;
    rh1 = bus.rsp1_valid && bus.rsp1_ready;
    if (bus.fpu_en) en_cnt++;
    if ((bus.rsp0_valid || bus.rsp1_valid) && !prev_rspv) rspv_cyc = cyc;
    prev_rspv = bus.rsp0_valid || bus.rsp1_valid;
    if (rh0 || rh1) begin
      rh_cyc = cyc; rsp_cnt++;
      last_y = rh1 ? bus.rsp1_y : bus.rsp0_y;
      last_err = rh1 ? bus.rsp1_err : bus.rsp0_err;
    end
    if (!rstn) begin
      m_busy = 0; m_rsp = 0; m_owner = 0; m_legal = 0; m_err = 0; m_last = 1;
      m_ctl = 0; m_x1 = 0; m_x2 = 0; m_y = 0; m_age = 0; armed = 1;
    end else if (armed && !m_busy) begin
      if (e_r0 || e_r1) begin
        m_owner = e_r1;
        m_last  = e_r1;
        m_ctl   = e_r1 ? bus.req1_ctl : bus.req0_ctl;
        m_x1    = e_r1 ? bus.req1_x1 : bus.req0_x1;
        m_x2    = e_r1 ? bus.req1_x2 : bus.req0_x2;
        m_busy  = 1;
        m_legal = (m_ctl <= 5'd20);
        m_age   = 1;
        if (!m_legal) begin m_rsp = 1; m_y = 0; m_err = 1; end
        acc_log.push_back(e_r1);
        acc_cyc = cyc;
      end
    end else if (armed && m_rsp) begin
      if (m_owner ? bus.rsp1_ready : bus.rsp0_ready) begin m_busy = 0; m_rsp = 0; end
    end else if (armed) begin
      if (m_age == 1) m_age = 2;
      else if (bus.fpu_ready) begin m_rsp = 1; m_y = bus.fpu_y; m_err = 0; end
      else if (m_age - 2 == 31) begin m_rsp = 1; m_y = 0; m_err = 1; end
      else m_age++;
    end
  end

  task automatic send(input bit who, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (who) begin bus.req1_valid = 1; bus.req1_ctl = c; bus.req1_x1 = a; bus.req1_x2 = b; end
    else     begin bus.req0_valid = 1; bus.req0_ctl = c; bus.req0_x1 = a; bus.req0_x2 = b; end
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (who ? hs1 : hs0) break;
      if (i == 100) begin tmo("send_accept"); break; end
    end
    if (who) bus.req1_valid = 0; else bus.req0_valid = 0;
  endtask

  task automatic wait_rsp(input bit who);
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (who ? rh1 : rh0) break;
      if (i == 100) begin tmo("wait_rsp"); break; end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      if (i == 200) begin tmo("wait_idle"); break; end
    end
  endtask

  task automatic pair();
    bit d0 = 0, d1 = 0;
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_ctl = 5'd2;  bus.req0_x1 = 32'h11; bus.req0_x2 = 32'h22;
    bus.req1_valid = 1; bus.req1_ctl = 5'd12; bus.req1_x1 = 32'h33; bus.req1_x2 = 32'h44;
    for (int i = 0; i < 200 && !(d0 && d1); i++) begin
      @(negedge clk);
      if (hs0) begin bus.req0_valid = 0; d0 = 1; end
      if (hs1) begin bus.req1_valid = 0; d1 = 1; end
    end
    if (!(d0 && d1)) tmo("pair_accept");
  endtask

  function automatic logic [4:0] rnd_ctl();
    if ($urandom_range(0, 7) == 0) return 5'(21 + $urandom_range(0, 10));
    return 5'($urandom_range(0, 20));
  endfunction

  initial begin
    int en0, rc;
    bus.req0_valid = 0; bus.req0_ctl = 0; bus.req0_x1 = 0; bus.req0_x2 = 0;
    bus.req1_valid = 0; bus.req1_ctl = 0; bus.req1_x1 = 0; bus.req1_x2 = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    bus.fpu_ready = 0; bus.fpu_y = 0;
    rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk); #3;
    chk("rst_busy", bus.busy, 0);
    chk("rst_en", bus.fpu_en, 0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_fpu_x1", bus.fpu_x1, 0);

    // depth-1 add: accept T, rsp_valid T+4, 1.0 + 2.0 = 3.0
    depth = 1; en0 = en_cnt;
    send(0, 5'd0, 32'h3F80_0000, 32'h4000_0000);
    wait_rsp(0);
    chk("t1_latency", rspv_cyc - acc_cyc, 4);
    chk("t1_y", last_y, 32'h4040_0000);
    chk("t1_err", last_err, 0);
    chk("t1_en_pulses", en_cnt - en0, 1);

    // simultaneous pairs from reset: req0, req1, req0, req1
    @(negedge clk); rstn = 0;
    @(negedge clk); rstn = 1;
    acc_log.delete();
    pair();
    pair();
    wait_idle();
    chk("t2_accepts", acc_log.size(), 4);
    if (acc_log.size() == 4) begin
      chk("t2_order0", acc_log[0], 0);
      chk("t2_order1", acc_log[1], 1);
      chk("t2_order2", acc_log[2], 0);
      chk("t2_order3", acc_log[3], 1);
    end

    // response back-pressure on requester 1 while requester 0 waits
    bus.rsp1_ready = 0;
    send(1, 5'd3, 32'hA5A5_0001, 32'h0F0F_1234);
    bus.req0_valid = 1; bus.req0_ctl = 5'd4; bus.req0_x1 = 32'h5; bus.req0_x2 = 32'h6;
    for (int i = 0; !bus.rsp1_valid; i++) begin
      @(negedge clk);
      if (i == 50) begin tmo("t3_rsp1_valid"); break; end
    end
    repeat (6) begin
      @(negedge clk); #3;
      chk("t3_rsp1_valid", bus.rsp1_valid, 1);
      chk("t3_rsp1_y", bus.rsp1_y, fpu_fn(5'd3, 32'hA5A5_0001, 32'h0F0F_1234));
      chk("t3_req0_ready", bus.req0_ready, 0);
    end
    @(negedge clk); bus.rsp1_ready = 1;
    wait_rsp(1);
    for (int i = 0; !hs0; i++) begin
      @(negedge clk);
      if (i == 50) begin tmo("t3_req0_accept"); break; end
    end
    bus.req0_valid = 0;
    chk("t3_accept_after_hs", acc_cyc - rh_cyc, 1);
    wait_rsp(0);

    // illegal opcode
    en0 = en_cnt;
    send(1, 5'd25, 32'h1, 32'h2);
    wait_rsp(1);
    chk("t4_latency", rspv_cyc - acc_cyc, 1);
    chk("t4_y", last_y, 0);
    chk("t4_err", last_err, 1);
    chk("t4_en_pulses", en_cnt - en0, 0);

    // hung FPU: 32 WAIT cycles then error; late done pulse while idle is ignored
    depth = -1;
    send(0, 5'd5, 32'h7, 32'h8);
    wait_rsp(0);
    chk("t5_latency", rspv_cyc - acc_cyc, 34);
    chk("t5_err", last_err, 1);
    chk("t5_y", last_y, 0);
    rc = rsp_cnt;
    @(negedge clk); stray = 1;
    @(negedge clk); stray = 0;
    repeat (4) @(negedge clk);
    #3;
    chk("t5_stray_rsp", rsp_cnt - rc, 0);
    chk("t5_stray_busy", bus.busy, 0);

    // reset during WAIT, then a normal operation
    send(0, 5'd7, 32'h9, 32'hA);
    repeat (4) @(negedge clk);
    rstn = 0;
    @(negedge clk); rstn = 1;
    #3;
    chk("t6_busy", bus.busy, 0);
    chk("t6_rsp0_valid", bus.rsp0_valid, 0);
    chk("t6_fpu_x1", bus.fpu_x1, 0);
    depth = 2; rc = rsp_cnt;
    send(1, 5'd9, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_rsp(1);
    chk("t6_err", last_err, 0);
    chk("t6_y", last_y, fpu_fn(5'd9, 32'hDEAD_BEEF, 32'h1234_5678));
    chk("t6_rsp_count", rsp_cnt - rc, 1);

    // randomized traffic with spurious FPU done pulses
    noise_on = 1;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (hs0) bus.req0_valid = 0;
      if (hs1) bus.req1_valid = 0;
      if (!bus.req0_valid && $urandom_range(0, 3) == 0) begin
        bus.req0_valid = 1; bus.req0_ctl = rnd_ctl(); bus.req0_x1 = $urandom; bus.req0_x2 = $urandom;
      end
      if (!bus.req1_valid && $urandom_range(0, 3) == 0) begin
        bus.req1_valid = 1; bus.req1_ctl = rnd_ctl(); bus.req1_x1 = $urandom; bus.req1_x2 = $urandom;
      end
      bus.rsp0_ready = ($urandom_range(0, 9) < 7);
      bus.rsp1_ready = ($urandom_range(0, 9) < 7);
      depth = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 3));
    end
    noise_on = 0;
    @(negedge clk);
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    wait_idle();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
